// File: rtl/proc_pkg.sv
// Shared definitions for the 16-bit bus processor: opcodes, sequencer steps and widths.
package proc_pkg;

    localparam int DATA_W   = 16;
    localparam int IR_W     = 9;
    localparam int NUM_REGS = 8;

    localparam logic [2:0] OP_MV   = 3'b000;
    localparam logic [2:0] OP_MVI  = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_SUB  = 3'b011;
    localparam logic [2:0] OP_MVNZ = 3'b100;

    typedef enum logic [1:0] {
        T0 = 2'd0,
        T1 = 2'd1,
        T2 = 2'd2,
        T3 = 2'd3
    } step_t;

endpackage

// File: rtl/dec3to8.sv
// 3-to-8 one-hot decoder with enable; all outputs low when disabled.
module dec3to8 (
    input  logic [2:0] sel_i,
    input  logic       en_i,
    output logic [7:0] onehot_o
);

    // Decode the selected register index to a single asserted line
    always_comb begin
        onehot_o = 8'd0;
        if (en_i) begin
            onehot_o[sel_i] = 1'b1;
        end else begin
            onehot_o = 8'd0;
        end
    end

endmodule

// File: rtl/proc_control_unit.sv
// Control sequencer: latches a 9-bit instruction and walks T0..T3 driving bus selects and load enables.
// Optional feature macro CTRL_MVNZ_EN turns opcode 100 into mvnz (move only when G is nonzero).
module proc_control_unit
    import proc_pkg::*;
(
    input  logic                Clock,
    input  logic                Resetn,
    input  logic                Run,
    input  logic [DATA_W-1:0]   DIN,
    input  logic                G_nz,
    output logic [NUM_REGS-1:0] R_out,
    output logic                G_out,
    output logic                DIN_out,
    output logic [NUM_REGS-1:0] R_in,
    output logic                A_in,
    output logic                G_in,
    output logic                AddSub,
    output logic                Done
);

    step_t             step_q, step_d;
    logic [IR_W-1:0]   ir_q, ir_d;
    logic [2:0]        op_s, x_s, y_s;
    logic              rout_x_s, rout_y_s, rin_x_s;
    logic [NUM_REGS-1:0] x_dec_s, y_dec_s;
    logic              unused_din_s;

    assign op_s = ir_q[8:6];
    assign x_s  = ir_q[5:3];
    assign y_s  = ir_q[2:0];

`ifdef CTRL_MVNZ_EN
    assign unused_din_s = ^DIN[DATA_W-IR_W-1:0];
`else
    assign unused_din_s = ^{DIN[DATA_W-IR_W-1:0], G_nz};
`endif

    // Next step and instruction capture; Run only matters in T0
    always_comb begin
        step_d = step_q;
        ir_d   = ir_q;
        case (step_q)
            T0: begin
                if (Run) begin
                    ir_d   = DIN[DATA_W-1:DATA_W-IR_W];
                    step_d = T1;
                end else begin
                    step_d = T0;
                end
            end
            T1: begin
                if ((op_s == OP_ADD) || (op_s == OP_SUB)) begin
                    step_d = T2;
                end else begin
                    step_d = T0;
                end
            end
            T2:      step_d = T3;
            T3:      step_d = T0;
            default: step_d = T0;
        endcase
    end

    // Sequencer state; async reset drops every enable at once
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            step_q <= T0;
            ir_q   <= {IR_W{1'b0}};
        end else begin
            step_q <= step_d;
            ir_q   <= ir_d;
        end
    end

    // Control decode from step and IR only (G_nz joins only for mvnz)
    always_comb begin
        rout_x_s = 1'b0;
        rout_y_s = 1'b0;
        rin_x_s  = 1'b0;
        G_out    = 1'b0;
        DIN_out  = 1'b0;
        A_in     = 1'b0;
        G_in     = 1'b0;
        AddSub   = 1'b0;
        Done     = 1'b0;
        case (step_q)
            T1: begin
                case (op_s)
                    OP_MV: begin
                        rout_y_s = 1'b1;
                        rin_x_s  = 1'b1;
                        Done     = 1'b1;
                    end
                    OP_MVI: begin
                        DIN_out = 1'b1;
                        rin_x_s = 1'b1;
                        Done    = 1'b1;
                    end
                    OP_ADD, OP_SUB: begin
                        rout_x_s = 1'b1;
                        A_in     = 1'b1;
                    end
`ifdef CTRL_MVNZ_EN
                    OP_MVNZ: begin
                        if (G_nz) begin
                            rout_y_s = 1'b1;
                            rin_x_s  = 1'b1;
                        end else begin
                            rout_y_s = 1'b0;
                            rin_x_s  = 1'b0;
                        end
                        Done = 1'b1;
                    end
`endif
                    default: Done = 1'b1;
                endcase
            end
            T2: begin
                rout_y_s = 1'b1;
                G_in     = 1'b1;
                AddSub   = (op_s == OP_SUB);
            end
            T3: begin
                G_out   = 1'b1;
                rin_x_s = 1'b1;
                Done    = 1'b1;
            end
            default: Done = 1'b0;
        endcase
    end

    dec3to8 u_dec_x (
        .sel_i    (x_s),
        .en_i     (rout_x_s | rin_x_s),
        .onehot_o (x_dec_s)
    );

    dec3to8 u_dec_y (
        .sel_i    (y_s),
        .en_i     (rout_y_s),
        .onehot_o (y_dec_s)
    );

    // Route decoder lines: X feeds loads and the first add/sub operand, Y the other sources
    always_comb begin
        if (rout_x_s) begin
            R_out = x_dec_s | y_dec_s;
        end else begin
            R_out = y_dec_s;
        end
        if (rin_x_s) begin
            R_in = x_dec_s;
        end else begin
            R_in = {NUM_REGS{1'b0}};
        end
    end

endmodule

// File: tb/tb_proc_control_unit.sv
// Self-checking bench for proc_control_unit: directed scenarios plus random programs vs. a step-table model.
module tb_proc_control_unit;
    import proc_pkg::*;

    typedef struct packed {
        logic [7:0] r_out;
        logic       g_out;
        logic       din_out;
        logic [7:0] r_in;
        logic       a_in;
        logic       g_in;
        logic       addsub;
        logic       done;
    } ctl_t;

    logic        Clock = 1'b0;
    logic        Resetn, Run, G_nz;
    logic [15:0] DIN;
    logic [7:0]  R_out, R_in;
    logic        G_out, DIN_out, A_in, G_in, AddSub, Done;

    int total = 0;
    int bad   = 0;

    proc_control_unit dut (
        .Clock(Clock), .Resetn(Resetn), .Run(Run), .DIN(DIN), .G_nz(G_nz),
        .R_out(R_out), .G_out(G_out), .DIN_out(DIN_out), .R_in(R_in),
        .A_in(A_in), .G_in(G_in), .AddSub(AddSub), .Done(Done)
    );

    always #5 Clock = ~Clock;

    function automatic ctl_t observe();
        ctl_t o;
        o.r_out = R_out; o.g_out = G_out; o.din_out = DIN_out; o.r_in = R_in;
        o.a_in = A_in; o.g_in = G_in; o.addsub = AddSub; o.done = Done;
        return o;
    endfunction

    function automatic int steps_of(input logic [8:0] ir);
        if (ir[8:6] == 3'd2 || ir[8:6] == 3'd3) return 3;
        return 1;
    endfunction

    // Expected controls for cycle k of an instruction (k=0 is the accepting T0 cycle)
    function automatic ctl_t model(input logic [8:0] ir, input int k, input logic gnz);
        ctl_t e = '0;
        logic [2:0] i = ir[8:6];
        logic [2:0] x = ir[5:3];
        logic [2:0] y = ir[2:0];
        if (k == 0) return e;
        case (i)
            3'd0: begin e.r_out = 8'd1 << y; e.r_in = 8'd1 << x; e.done = 1'b1; end
            3'd1: begin e.din_out = 1'b1; e.r_in = 8'd1 << x; e.done = 1'b1; end
            3'd2, 3'd3: begin
                if (k == 1) begin e.r_out = 8'd1 << x; e.a_in = 1'b1; end
                if (k == 2) begin e.r_out = 8'd1 << y; e.g_in = 1'b1; e.addsub = (i == 3'd3); end
                if (k == 3) begin e.g_out = 1'b1; e.r_in = 8'd1 << x; e.done = 1'b1; end
            end
            3'd4: begin
`ifdef CTRL_MVNZ_EN
                if (gnz) begin e.r_out = 8'd1 << y; e.r_in = 8'd1 << x; end
`endif
                e.done = 1'b1;
            end
            default: e.done = 1'b1;
        endcase
        return e;
    endfunction

    function automatic bit bus_onehot_ok();
        return ($countones(R_out) + int'(G_out) + int'(DIN_out)) <= 1;
    endfunction

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic drive(input logic run, input logic [15:0] din, input logic gnz);
        Run = run; DIN = din; G_nz = gnz;
        #1;
    endtask

    task automatic test_reset();
        logic [8:0] add_ir = 9'b010_010_011;
        Resetn = 1'b0;
        drive(1'b0, 16'h0000, 1'b0);
        repeat (2) tick();
        total++; if (observe() !== ctl_t'(0)) begin bad++; $display("FAIL reset_hold got=%h want=0", observe()); end
        @(negedge Clock) Resetn = 1'b1;
        for (int n = 0; n < 3; n++) begin
            tick();
            total++; if (observe() !== ctl_t'(0)) begin bad++; $display("FAIL idle_after_reset got=%h want=0", observe()); end
        end
        drive(1'b1, {add_ir, 7'd0}, 1'b0);
        tick();
        drive(1'b0, 16'h0000, 1'b0);
        tick();
        total++; if (observe() !== model(add_ir, 2, 1'b0)) begin bad++; $display("FAIL pre_reset_t2 got=%h want=%h", observe(), model(add_ir, 2, 1'b0)); end
        Resetn = 1'b0;
        #1;
        total++; if (observe() !== ctl_t'(0)) begin bad++; $display("FAIL async_reset got=%h want=0", observe()); end
        tick();
        total++; if (observe() !== ctl_t'(0)) begin bad++; $display("FAIL reset_held got=%h want=0", observe()); end
        @(negedge Clock) Resetn = 1'b1;
        for (int n = 0; n < 2; n++) begin
            tick();
            total++; if (observe() !== ctl_t'(0)) begin bad++; $display("FAIL idle_after_release got=%h want=0", observe()); end
        end
    endtask

    task automatic test_mvi_mv();
        logic [8:0] prog [2] = '{9'b001_101_000, 9'b000_001_101};
        for (int n = 0; n < 2; n++) begin
            drive(1'b1, {prog[n], 7'($urandom)}, 1'b0);
            total++; if (observe() !== ctl_t'(0)) begin bad++; $display("FAIL mvi_mv_t0 n=%0d got=%h want=0", n, observe()); end
            tick();
            drive(1'b0, 16'h0140, 1'b0);
            total++; if (observe() !== model(prog[n], 1, 1'b0)) begin bad++; $display("FAIL mvi_mv_t1 n=%0d got=%h want=%h", n, observe(), model(prog[n], 1, 1'b0)); end
            tick();
        end
    endtask

    task automatic test_add_sub();
        logic [8:0] prog [2] = '{9'b010_010_011, 9'b011_000_111};
        int done_at, done_cnt;
        for (int n = 0; n < 2; n++) begin
            done_at = -1; done_cnt = 0;
            drive(1'b1, {prog[n], 7'($urandom)}, 1'b0);
            tick();
            for (int k = 1; k <= 3; k++) begin
                drive(1'($urandom), 16'($urandom), 1'($urandom));
                total++; if (observe() !== model(prog[n], k, 1'b0)) begin bad++; $display("FAIL add_sub n=%0d step=%0d got=%h want=%h", n, k, observe(), model(prog[n], k, 1'b0)); end
                if (Done) begin done_cnt++; done_at = k; end
                tick();
            end
            total++; if (done_at != 3 || done_cnt != 1) begin bad++; $display("FAIL add_sub_latency n=%0d got_at=%0d got_cnt=%0d want_at=3 want_cnt=1", n, done_at, done_cnt); end
        end
    endtask

    task automatic test_mvnz();
        logic [8:0] ir = 9'b100_011_110;
        for (int g = 1; g >= 0; g--) begin
            drive(1'b1, {ir, 7'($urandom)}, 1'(g));
            tick();
            drive(1'b0, 16'($urandom), 1'(g));
            total++; if (observe() !== model(ir, 1, 1'(g))) begin bad++; $display("FAIL mvnz gnz=%0d got=%h want=%h", g, observe(), model(ir, 1, 1'(g))); end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        logic [8:0] prog [3] = '{9'b000_100_001, 9'b010_110_110, 9'b000_011_011};
        int dones = 0, cycles = 0, onehot_bad = 0;
        for (int n = 0; n < 3; n++) begin
            for (int k = 0; k <= steps_of(prog[n]); k++) begin
                drive(1'b1, {prog[n], 7'($urandom)}, 1'b0);
                total++; if (observe() !== model(prog[n], k, 1'b0)) begin bad++; $display("FAIL b2b n=%0d step=%0d got=%h want=%h", n, k, observe(), model(prog[n], k, 1'b0)); end
                if (!bus_onehot_ok()) onehot_bad++;
                if (Done) dones++;
                cycles++;
                tick();
            end
        end
        total++; if (dones != 3 || cycles != 8 || onehot_bad != 0) begin bad++; $display("FAIL b2b_summary dones=%0d cycles=%0d onehot_bad=%0d want 3/8/0", dones, cycles, onehot_bad); end
    endtask

    task automatic test_random();
        logic [8:0] ir;
        logic gnz;
        int dones = 0, onehot_bad = 0, n_instr = 150;
        for (int n = 0; n < n_instr; n++) begin
            ir = 9'($urandom);
            gnz = 1'($urandom);
            for (int idle = 0; idle < int'($urandom_range(0, 2)); idle++) begin
                drive(1'b0, 16'($urandom), 1'($urandom));
                total++; if (observe() !== ctl_t'(0)) begin bad++; $display("FAIL rand_idle n=%0d got=%h want=0", n, observe()); end
                tick();
            end
            for (int k = 0; k <= steps_of(ir); k++) begin
                if (k == 0) drive(1'b1, {ir, 7'($urandom)}, gnz);
                else        drive(1'($urandom), 16'($urandom), gnz);
                total++; if (observe() !== model(ir, k, gnz)) begin bad++; $display("FAIL rand n=%0d ir=%h step=%0d got=%h want=%h", n, ir, k, observe(), model(ir, k, gnz)); end
                if (!bus_onehot_ok()) onehot_bad++;
                if (Done) dones++;
                tick();
            end
        end
        total++; if (dones != n_instr || onehot_bad != 0) begin bad++; $display("FAIL rand_summary dones=%0d want=%0d onehot_bad=%0d", dones, n_instr, onehot_bad); end
    endtask

    initial begin
        Resetn = 1'b1; Run = 1'b0; DIN = 16'h0000; G_nz = 1'b0;
        #1;
        test_reset();
        test_mvi_mv();
        test_add_sub();
        test_mvnz();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
